// File: rtl/instr_fetch_unit.sv
// Program counter owner and instruction fetch FSM for the RV32I core.
// Optional feature macro: MISALIGN_TRAP_EN (trap on misaligned next-PC instead of forcing alignment).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  N_PC,
  input  logic        branch,
  input  logic        br_taken,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic        fetch_err,
  output logic        misalign_exc
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_ERR   = 3'd4,
    S_TRAP  = 3'd5
  } state_t;

  state_t        state_r;
  logic [31:0]   pc_r;
  logic [31:0]   instr_r;
  logic          instr_valid_r;
  logic          imem_req_r;
  logic          fetch_err_r;
  logic          misalign_exc_r;
  logic [TW-1:0] timer_r;

  logic [31:0]   pc_plus4_s;
  logic [31:0]   next_pc_raw_s;
  logic [31:0]   next_pc_s;
  logic          misalign_s;

  assign pc_plus4_s = pc_r + 32'd4;

  // Next-PC selection from the control unit's decode of the current instruction
  always_comb begin
    next_pc_raw_s = pc_plus4_s;
    case (N_PC)
      2'b00:   next_pc_raw_s = pc_plus4_s;
      2'b01:   next_pc_raw_s = pc_r + imm;
      2'b10:   next_pc_raw_s = (branch && br_taken) ? (pc_r + imm) : pc_plus4_s;
      2'b11:   next_pc_raw_s = alu_result & ~32'h0000_0001;
      default: next_pc_raw_s = pc_plus4_s;
    endcase
  end

  // Alignment handling: either flag the bad target or silently word-align it
  always_comb begin
`ifdef MISALIGN_TRAP_EN
    next_pc_s  = next_pc_raw_s;
    misalign_s = (next_pc_raw_s[1:0] != 2'b00);
`else
    next_pc_s  = next_pc_raw_s & 32'hFFFF_FFFC;
    misalign_s = 1'b0;
`endif
  end

  // Fetch FSM: owns pc, the request pulse, the instruction latch and sticky errors
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= S_IDLE;
      pc_r           <= RESET_PC;
      instr_r        <= 32'h0000_0000;
      instr_valid_r  <= 1'b0;
      imem_req_r     <= 1'b0;
      fetch_err_r    <= 1'b0;
      misalign_exc_r <= 1'b0;
      timer_r        <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          imem_req_r <= 1'b1;
          state_r    <= S_REQ;
        end
        S_REQ: begin
          imem_req_r <= 1'b0;
          timer_r    <= '0;
          state_r    <= S_WAIT;
        end
        S_WAIT: begin
          imem_req_r <= 1'b0;
          if (imem_rvalid) begin
            instr_r       <= imem_rdata;
            instr_valid_r <= 1'b1;
            state_r       <= S_VALID;
          end else if (timer_r == TIMER_LAST) begin
            fetch_err_r <= 1'b1;
            state_r     <= S_ERR;
          end else begin
            timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        S_VALID: begin
          if (instr_ready) begin
            instr_valid_r <= 1'b0;
            if (misalign_s) begin
              // pc keeps the offending instruction's address for the trap handler
              misalign_exc_r <= 1'b1;
              imem_req_r     <= 1'b0;
              state_r        <= S_TRAP;
            end else begin
              pc_r       <= next_pc_s;
              imem_req_r <= 1'b1;
              state_r    <= S_REQ;
            end
          end else begin
            imem_req_r <= 1'b0;
          end
        end
        S_ERR, S_TRAP: begin
          imem_req_r <= 1'b0;
        end
        default: begin
          imem_req_r <= 1'b0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req     = imem_req_r;
  assign imem_addr    = pc_r;
  assign instr        = instr_r;
  assign instr_valid  = instr_valid_r;
  assign pc           = pc_r;
  assign pc_plus4     = pc_plus4_s;
  assign fetch_err    = fetch_err_r;
  assign misalign_exc = misalign_exc_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory responder with variable latency
// plus a transaction-level PC model driven by randomized control inputs.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  N_PC;
  logic        branch;
  logic        br_taken;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic        fetch_err;
  logic        misalign_exc;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;

  int          mem_lat = 1;
  bit          mem_on  = 1'b1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr_lat;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
    .pc_plus4(pc_plus4), .N_PC(N_PC), .branch(branch), .br_taken(br_taken),
    .imm(imm), .alu_result(alu_result), .fetch_err(fetch_err),
    .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  // Unique instruction word per address (odd multiplier is a bijection)
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [1:0] sel,
                                           input logic br, input logic tk,
                                           input logic [31:0] im, input logic [31:0] alu);
    logic [31:0] t;
    if (sel == 2'd0)      t = cur + 32'd4;
    else if (sel == 2'd1) t = cur + im;
    else if (sel == 2'd2) t = (br && tk) ? cur + im : cur + 32'd4;
    else                  t = {alu[31:1], 1'b0};
`ifndef MISALIGN_TRAP_EN
    t[1:0] = 2'b00;
`endif
    return t;
  endfunction

  // Memory model: answers each request after mem_lat cycles
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt = mem_cnt - 1;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr_lat);
      end
    end
    if (imem_req && mem_on) begin
      mem_cnt      = mem_lat;
      mem_addr_lat = imem_addr;
    end
  end

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) begin
      checks++; errors++;
      $display("FAIL wait_valid: instr_valid=0 after %0d cycles, required 1", n);
    end
  endtask

  // Accept the presented instruction; returns the request seen on the following cycle
  task automatic do_accept(input logic [1:0] sel, input logic br, input logic tk,
                           input logic [31:0] im, input logic [31:0] alu,
                           output logic req_s, output logic [31:0] addr_s);
    N_PC = sel; branch = br; br_taken = tk; imm = im; alu_result = alu;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    N_PC = 2'($urandom); branch = 1'($urandom); br_taken = 1'($urandom);
    imm = $urandom; alu_result = $urandom;
    req_s  = imem_req;
    addr_s = imem_addr;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0) begin
      errors++; $display("FAIL reset_ctrl: req=%b valid=%b instr=%h, required 0 0 00000000", imem_req, instr_valid, instr);
    end
    checks++;
    if (pc !== 32'h0 || imem_addr !== 32'h0 || pc_plus4 !== 32'h4) begin
      errors++; $display("FAIL reset_pc: pc=%h addr=%h pc4=%h, required 0 0 4", pc, imem_addr, pc_plus4);
    end
    checks++;
    if (fetch_err !== 1'b0 || misalign_exc !== 1'b0) begin
      errors++; $display("FAIL reset_err: err=%b mis=%b, required 0 0", fetch_err, misalign_exc);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL first_req: req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL wait_cycle: valid=%b req=%b, required 0 0", instr_valid, imem_req);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== mem_word(32'h0)) begin
      errors++; $display("FAIL first_valid: valid=%b pc=%h instr=%h, required 1 0 %h", instr_valid, pc, instr, mem_word(32'h0));
    end
    exp_pc = 32'h0;
  endtask

  task automatic test_sequential();
    logic req_s; logic [31:0] addr_s;
    for (int i = 0; i < 2; i++) begin
      do_accept(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, req_s, addr_s);
      exp_pc = exp_pc + 32'd4;
      checks++;
      if (req_s !== 1'b1 || addr_s !== exp_pc) begin
        errors++; $display("FAIL seq_req%0d: req=%b addr=%h, required 1 %h", i, req_s, addr_s, exp_pc);
      end
      wait_valid();
      checks++;
      if (pc !== exp_pc || instr !== mem_word(exp_pc)) begin
        errors++; $display("FAIL seq_instr%0d: pc=%h instr=%h, required %h %h", i, pc, instr, exp_pc, mem_word(exp_pc));
      end
    end
  endtask

  task automatic test_hold();
    bit bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      N_PC = 2'($urandom); imm = $urandom; alu_result = $urandom;
      @(negedge clk);
      if (instr_valid !== 1'b1 || pc !== exp_pc || instr !== mem_word(exp_pc) || imem_req !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL hold: valid=%b pc=%h instr=%h req=%b, required 1 %h %h 0", instr_valid, pc, instr, imem_req, exp_pc, mem_word(exp_pc));
    end
  endtask

  task automatic test_jal_branch();
    logic [1:0]  t_sel [5] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b10};
    logic        t_br  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        t_tk  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] t_imm [5] = '{32'h100, 32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFF8, 32'h40};
    logic [31:0] t_alu [5] = '{32'h0, 32'h0, 32'h108, 32'h0, 32'h0};
    logic [31:0] t_exp [5] = '{32'h108, 32'h10C, 32'h108, 32'h100, 32'h104};
    logic req_s; logic [31:0] addr_s;
    for (int i = 0; i < 5; i++) begin
      do_accept(t_sel[i], t_br[i], t_tk[i], t_imm[i], t_alu[i], req_s, addr_s);
      checks++;
      if (req_s !== 1'b1 || addr_s !== t_exp[i]) begin
        errors++; $display("FAIL ctl_step%0d: req=%b addr=%h, required 1 %h", i, req_s, addr_s, t_exp[i]);
      end
      exp_pc = t_exp[i];
      wait_valid();
      checks++;
      if (pc !== exp_pc || instr !== mem_word(exp_pc)) begin
        errors++; $display("FAIL ctl_instr%0d: pc=%h instr=%h, required %h %h", i, pc, instr, exp_pc, mem_word(exp_pc));
      end
    end
  endtask

  task automatic test_jalr();
    logic req_s; logic [31:0] addr_s;
    do_accept(2'b11, 1'b0, 1'b0, 32'h0, 32'h201, req_s, addr_s);
    checks++;
    if (req_s !== 1'b1 || addr_s !== 32'h200) begin
      errors++; $display("FAIL jalr_201: req=%b addr=%h, required 1 00000200", req_s, addr_s);
    end
    exp_pc = 32'h200;
    wait_valid();
    do_accept(2'b11, 1'b0, 1'b0, 32'h0, 32'h203, req_s, addr_s);
`ifdef MISALIGN_TRAP_EN
    begin
      bit bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (imem_req !== 1'b0 || misalign_exc !== 1'b1 || pc !== 32'h200) bad = 1'b1;
        @(negedge clk);
      end
      checks++;
      if (req_s !== 1'b0 || bad) begin
        errors++; $display("FAIL jalr_trap: req=%b mis=%b pc=%h, required 0 1 00000200", req_s, misalign_exc, pc);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wait_valid();
      exp_pc = 32'h0;
    end
`else
    checks++;
    if (req_s !== 1'b1 || addr_s !== 32'h200 || misalign_exc !== 1'b0) begin
      errors++; $display("FAIL jalr_203: req=%b addr=%h mis=%b, required 1 00000200 0", req_s, addr_s, misalign_exc);
    end
    exp_pc = 32'h200;
    wait_valid();
`endif
  endtask

  task automatic test_wrap();
    logic req_s; logic [31:0] addr_s;
    do_accept(2'b11, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, req_s, addr_s);
    wait_valid();
    checks++;
    if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
      errors++; $display("FAIL wrap_pc4: pc=%h pc4=%h, required fffffffc 00000000", pc, pc_plus4);
    end
    do_accept(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, req_s, addr_s);
    checks++;
    if (req_s !== 1'b1 || addr_s !== 32'h0) begin
      errors++; $display("FAIL wrap_req: req=%b addr=%h, required 1 00000000", req_s, addr_s);
    end
    exp_pc = 32'h0;
    wait_valid();
  endtask

  task automatic test_random();
    logic req_s; logic [31:0] addr_s;
    logic [1:0] sel; logic br, tk; logic [31:0] im, alu, nxt;
    for (int i = 0; i < 40; i++) begin
      mem_lat = $urandom_range(1, 4);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sel = 2'($urandom); br = 1'($urandom); tk = 1'($urandom);
      im = $urandom; alu = $urandom;
`ifdef MISALIGN_TRAP_EN
      im  = im & 32'hFFFF_FFFC;
      alu = alu & 32'hFFFF_FFFC;
`endif
      nxt = ref_next(exp_pc, sel, br, tk, im, alu);
      do_accept(sel, br, tk, im, alu, req_s, addr_s);
      checks++;
      if (req_s !== 1'b1 || addr_s !== nxt) begin
        errors++; $display("FAIL rand_req%0d: sel=%0d req=%b addr=%h, required 1 %h", i, sel, req_s, addr_s, nxt);
      end
      exp_pc = nxt;
      wait_valid();
      checks++;
      if (pc !== exp_pc || instr !== mem_word(exp_pc) || pc_plus4 !== exp_pc + 32'd4) begin
        errors++; $display("FAIL rand_instr%0d: pc=%h instr=%h pc4=%h, required %h %h %h", i, pc, instr, pc_plus4, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
      end
    end
    mem_lat = 1;
  endtask

  task automatic test_timeout();
    logic req_s; logic [31:0] addr_s;
    bit bad = 1'b0;
    mem_on = 1'b0;
    do_accept(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, req_s, addr_s);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (fetch_err !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL timeout_early: fetch_err rose within 16 wait cycles, required 0");
    end
    @(negedge clk);
    checks++;
    if (fetch_err !== 1'b1) begin
      errors++; $display("FAIL timeout_err: fetch_err=%b, required 1", fetch_err);
    end
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || fetch_err !== 1'b1 || instr_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL timeout_terminal: req=%b err=%b valid=%b, required 0 1 0", imem_req, fetch_err, instr_valid);
    end
    mem_on = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (fetch_err !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: fetch_err=%b, required 0", fetch_err);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL timeout_refetch: req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
    end
    exp_pc = 32'h0;
    wait_valid();
  endtask

  task automatic test_reset_mid_wait();
    logic req_s; logic [31:0] addr_s;
    mem_lat = 2;
    do_accept(2'b11, 1'b0, 1'b0, 32'h0, 32'h40, req_s, addr_s);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (pc !== 32'h0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL midwait_reset: pc=%h valid=%b, required 00000000 0", pc, instr_valid);
    end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL midwait_req: req=%b addr=%h valid=%b, required 1 00000000 0", imem_req, imem_addr, instr_valid);
    end
    wait_valid();
    checks++;
    if (pc !== 32'h0 || instr !== mem_word(32'h0)) begin
      errors++; $display("FAIL midwait_instr: pc=%h instr=%h, required 00000000 %h", pc, instr, mem_word(32'h0));
    end
    mem_lat = 1;
  endtask

  initial begin
    rst = 1'b1; instr_ready = 1'b0; N_PC = 2'b00; branch = 1'b0; br_taken = 1'b0;
    imm = 32'h0; alu_result = 32'h0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    exp_pc = 32'h0;
    test_reset();
    test_sequential();
    test_hold();
    test_jal_branch();
    test_jalr();
    test_wrap();
    test_random();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
